// File: rtl/pwm_ds_decimator.sv
// PWM high-time to 2nd-order CIC decimator.
// Measures high cycles per PWM period and decimates by R=2^k.
module pwm_ds_decimator #(
  parameter int PWM_BITS       = 7,
  parameter int MAX_LOG2_DECIM = 6
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   en,
  input  logic                                   pwm_in,
  input  logic                                   pulse_done,
  input  logic [2:0]                             log2_decim,
  output logic [PWM_BITS+2+2*MAX_LOG2_DECIM-1:0] sample,
  output logic                                   sample_valid,
  output logic                                   overflow
);

  localparam int CNT_BITS = PWM_BITS + 2;
  localparam int OUT_BITS = CNT_BITS + 2*MAX_LOG2_DECIM;
  localparam int PC_BITS  = 8;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ALIGN,
    WARMUP,
    RUN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_BITS-1:0] r_cnt;
  logic [OUT_BITS-1:0] r_i1;
  logic [OUT_BITS-1:0] r_i2;
  logic [OUT_BITS-1:0] r_i2_last;
  logic [OUT_BITS-1:0] r_c1_last;
  logic [OUT_BITS-1:0] r_sample;
  logic [PC_BITS-1:0]  r_pc;
  logic [2:0]          r_k;
  logic                r_valid;
  logic                r_ovf;

  logic                w_inc;
  logic                w_sat;
  logic                w_pd;
  logic [CNT_BITS-1:0] w_width;
  logic [2:0]          w_k_req;
  logic [PC_BITS-1:0]  w_r;
  logic [PC_BITS-1:0]  w_pcn;
  logic                w_dec;
  logic [OUT_BITS-1:0] w_i1n;
  logic [OUT_BITS-1:0] w_i2n;
  logic [OUT_BITS-1:0] w_c1;
  logic [OUT_BITS-1:0] w_out;
  logic                w_strobe;

  assign w_inc   = en & pwm_in;
  assign w_sat   = w_inc && (r_cnt == CNT_MAX);
  assign w_pd    = en & pulse_done;
  assign w_width = (w_inc && !w_sat) ? r_cnt + 1'b1 : r_cnt;

  assign w_k_req = (int'(log2_decim) > MAX_LOG2_DECIM)
                 ? 3'(MAX_LOG2_DECIM) : log2_decim;

  assign w_r   = PC_BITS'(1) << r_k;
  assign w_pcn = r_pc + PC_BITS'(1);
  assign w_dec = (w_pcn == w_r);

  // Arithmetic wraps at OUT_BITS; the comb difference cancels the wrap.
  assign w_i1n = r_i1 + OUT_BITS'(w_width);
  assign w_i2n = r_i2 + w_i1n;
  assign w_c1  = w_i2n - r_i2_last;
  assign w_out = w_c1 - r_c1_last;

  always_comb begin
    w_state_nxt = r_state;
    w_strobe    = 1'b0;
    if (w_pd) begin
      unique case (r_state)
        ALIGN:  w_state_nxt = WARMUP;
        WARMUP: begin
          if (w_dec)
            w_state_nxt = (w_k_req != r_k) ? ALIGN : RUN;
        end
        RUN: begin
          if (w_dec) begin
            w_strobe = 1'b1;
            if (w_k_req != r_k)
              w_state_nxt = ALIGN;
          end
        end
        default: w_state_nxt = ALIGN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ALIGN;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_i1      <= '0;
      r_i2      <= '0;
      r_i2_last <= '0;
      r_c1_last <= '0;
      r_pc      <= '0;
      r_k       <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_valid <= w_strobe;
      if (w_strobe)
        r_sample <= w_out;
      if (w_sat)
        r_ovf <= 1'b1;
      if (en)
        r_cnt <= w_pd ? '0 : w_width;
      if (w_pd) begin
        if (r_state == ALIGN) begin
          r_i1      <= '0;
          r_i2      <= '0;
          r_i2_last <= '0;
          r_c1_last <= '0;
          r_pc      <= '0;
          r_k       <= w_k_req;
        end else begin
          r_i1 <= w_i1n;
          r_i2 <= w_i2n;
          if (w_dec) begin
            r_i2_last <= w_i2n;
            r_c1_last <= w_c1;
            r_pc      <= '0;
          end else begin
            r_pc <= w_pcn;
          end
        end
      end
    end
  end

  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_pwm_ds_decimator.sv
// Directed bench for pwm_ds_decimator.
// Drives PWM periods on the falling edge, checks after it.
module tb_pwm_ds_decimator;

  localparam int OUT_BITS = 21;

  logic                clk;
  logic                reset;
  logic                en;
  logic                pwm_in;
  logic                pulse_done;
  logic [2:0]          log2_decim;
  logic [OUT_BITS-1:0] sample;
  logic                sample_valid;
  logic                overflow;

  int n_cmp;
  int n_err;
  int n_valid;
  int base;
  logic [OUT_BITS-1:0] last_s;

  pwm_ds_decimator dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .pwm_in       (pwm_in),
    .pulse_done   (pulse_done),
    .log2_decim   (log2_decim),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sample_valid) begin
      n_valid = n_valid + 1;
      last_s  = sample;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached, required run to finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    pwm_in     = 1'b0;
    pulse_done = 1'b0;
    #1;
  endtask

  task automatic period(input int hi, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      pwm_in     = (i < hi);
      pulse_done = (i == len - 1);
    end
    settle();
  endtask

  task automatic periods(input int n, input int hi, input int len);
    for (int i = 0; i < n; i++)
      period(hi, len);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    n_valid    = 0;
    last_s     = '0;
    reset      = 1'b1;
    en         = 1'b0;
    pwm_in     = 1'b0;
    pulse_done = 1'b0;
    log2_decim = 3'd2;
    repeat (3) @(negedge clk);
    #1;
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;

    // k=2, w=10: warmup block silent, then 160 per block
    period(3, 5);
    base = n_valid;
    periods(4, 10, 12);
    check("k2_warm_nv", n_valid - base, 0);
    periods(4, 10, 12);
    check("k2_s1_nv", n_valid - base, 1);
    check("k2_s1", last_s, 160);

    // en=0 gap mid-period with a pulse_done inside it
    base = n_valid;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pwm_in = 1'b1;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      en         = 1'b0;
      pwm_in     = 1'b1;
      pulse_done = (i == 25);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en         = 1'b1;
      pwm_in     = 1'b1;
      pulse_done = (i == 5);
    end
    settle();
    check("gap_nv", n_valid - base, 0);
    check("gap_ovf", overflow, 0);
    periods(3, 10, 12);
    check("gap_after_nv", n_valid - base, 1);
    check("gap_after_s", last_s, 160);

    // k change 2->3: realign, then gain 64
    log2_decim = 3'd3;
    periods(4, 10, 12);
    period(10, 12);
    base = n_valid;
    periods(8, 10, 12);
    check("k3_warm_nv", n_valid - base, 0);
    periods(8, 10, 12);
    check("k3_s1_nv", n_valid - base, 1);
    check("k3_s1", last_s, 640);
    periods(8, 10, 12);
    check("k3_s2_nv", n_valid - base, 2);
    check("k3_s2", last_s, 640);

    // k=0: sample tracks current w
    log2_decim = 3'd0;
    periods(8, 10, 12);
    period(7, 9);
    base = n_valid;
    period(3, 5);
    check("k0_warm_nv", n_valid - base, 0);
    period(5, 7);
    check("k0_s5a", last_s, 5);
    period(3, 5);
    check("k0_s3", last_s, 3);
    period(5, 7);
    check("k0_s5b", last_s, 5);
    check("k0_nv", n_valid - base, 3);

    // saturation: 517 high cycles -> 511
    period(517, 517);
    check("sat_w", last_s, 511);
    check("sat_ovf", overflow, 1);
    period(3, 5);
    check("sat_reload", last_s, 3);
    check("sat_ovf_hold", overflow, 1);

    // k=7 clamps to 6: gain 4096
    log2_decim = 3'd7;
    period(2, 4);
    period(2, 4);
    base = n_valid;
    periods(64, 2, 4);
    check("k6_warm_nv", n_valid - base, 0);
    periods(64, 2, 4);
    check("k6_nv", n_valid - base, 1);
    check("k6_s", last_s, 8192);
    check("k6_ovf", overflow, 1);

    // async reset mid-period while running
    log2_decim = 3'd0;
    periods(2, 2, 4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      pwm_in = 1'b1;
    end
    #2;
    reset = 1'b1;
    #1;
    check("arst_sample", sample, 0);
    check("arst_valid", sample_valid, 0);
    check("arst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    pwm_in = 1'b0;
    reset  = 1'b0;
    base   = n_valid;
    period(4, 6);
    period(4, 6);
    check("post_rst_nv0", n_valid - base, 0);
    period(4, 6);
    check("post_rst_nv1", n_valid - base, 1);
    check("post_rst_s", last_s, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
